pearson_hash_ctrl: RTL and testbench

PEARSON_HASH_CTRL -- requirements
Module: pearson_hash_ctrl

---
 rtl/pearson_hash_ctrl.sv | 149 ++++++++++++++
 tb/tb_pearson_hash_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/pearson_hash_ctrl.sv
// Pearson hash controller: one message byte per two cycles, hashed through an external permutation table.
// Optional saturating byte counter enabled by defining PEARSON_BYTE_CNT_EN.
module pearson_hash_ctrl #(
    parameter int unsigned                  DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0]        SEED       = 8'h00
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] msg_byte,
    input  logic                  msg_valid,
    input  logic                  msg_last,
    output logic                  msg_ready,
    output logic [DATA_WIDTH-1:0] tbl_addr,
    output logic                  tbl_cs,
    output logic                  tbl_oe,
    output logic                  tbl_we,
    input  logic [DATA_WIDTH-1:0] tbl_data,
    output logic [DATA_WIDTH-1:0] hash_out,
    output logic                  hash_valid,
    output logic                  busy,
    output logic [15:0]           byte_count
);

    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {IDLE, ACCEPT, READ, DONE} state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] h_q, h_d;
    logic [DATA_WIDTH-1:0] idx_q, idx_d;
    logic                  last_q, last_d;
    logic [DATA_WIDTH-1:0] hash_out_q, hash_out_d;
    logic [DATA_WIDTH-1:0] tbl_addr_q, tbl_addr_d;
    logic                  tbl_rd_q, tbl_rd_d;
    logic                  msg_ready_q, msg_ready_d;
    logic                  hash_valid_q, hash_valid_d;
    logic                  busy_q, busy_d;

    // Next-state logic; outputs are decoded from the next state so they are registered yet aligned with it.
    always_comb begin
        state_d    = state_q;
        h_d        = h_q;
        idx_d      = idx_q;
        last_d     = last_q;
        hash_out_d = hash_out_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ACCEPT;
                    h_d     = SEED;
                end
            end
            ACCEPT: begin
                if (msg_valid) begin
                    idx_d   = h_q ^ msg_byte;
                    last_d  = msg_last;
                    state_d = READ;
                end
            end
            READ: begin
                h_d = tbl_data;
                if (last_q) begin
                    state_d    = DONE;
                    hash_out_d = tbl_data;
                end else begin
                    state_d = ACCEPT;
                end
            end
            DONE: begin
                if (start) begin
                    state_d = ACCEPT;
                    h_d     = SEED;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        msg_ready_d  = (state_d == ACCEPT);
        busy_d       = (state_d == ACCEPT) || (state_d == READ);
        tbl_rd_d     = (state_d == READ);
        tbl_addr_d   = (state_d == READ) ? idx_d : '0;
        hash_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            h_q          <= SEED;
            idx_q        <= '0;
            last_q       <= 1'b0;
            hash_out_q   <= '0;
            tbl_addr_q   <= '0;
            tbl_rd_q     <= 1'b0;
            msg_ready_q  <= 1'b0;
            hash_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            h_q          <= h_d;
            idx_q        <= idx_d;
            last_q       <= last_d;
            hash_out_q   <= hash_out_d;
            tbl_addr_q   <= tbl_addr_d;
            tbl_rd_q     <= tbl_rd_d;
            msg_ready_q  <= msg_ready_d;
            hash_valid_q <= hash_valid_d;
            busy_q       <= busy_d;
        end
    end

    assign msg_ready  = msg_ready_q;
    assign busy       = busy_q;
    assign tbl_addr   = tbl_addr_q;
    assign tbl_cs     = tbl_rd_q;
    assign tbl_oe     = tbl_rd_q;
    assign tbl_we     = 1'b0;
    assign hash_out   = hash_out_q;
    assign hash_valid = hash_valid_q;

`ifdef PEARSON_BYTE_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Cleared on an accepted start, saturating increment per accepted byte.
    always_comb begin
        cnt_d = cnt_q;
        if (start && ((state_q == IDLE) || (state_q == DONE))) begin
            cnt_d = '0;
        end else if ((state_q == ACCEPT) && msg_valid && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign byte_count = cnt_q;
`else
    assign byte_count = '0;
`endif

endmodule

// File: tb/tb_pearson_hash_ctrl.sv
// Directed bench for pearson_hash_ctrl with an identity table; two instances (SEED 00 and FF) share stimulus.
module tb_pearson_hash_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] msg_byte;
    logic       msg_valid;
    logic       msg_last;

    logic       ready0, cs0, oe0, we0, hv0, busy0;
    logic       ready1, cs1, oe1, we1, hv1, busy1;
    logic [7:0] addr0, hout0, addr1, hout1;
    logic [15:0] cnt0, cnt1;
    logic [7:0] tdata0, tdata1;

    assign tdata0 = addr0;
    assign tdata1 = addr1;

    always #5 clk = ~clk;

    pearson_hash_ctrl #(.DATA_WIDTH(8), .SEED(8'h00)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .msg_byte(msg_byte),
        .msg_valid(msg_valid), .msg_last(msg_last), .msg_ready(ready0),
        .tbl_addr(addr0), .tbl_cs(cs0), .tbl_oe(oe0), .tbl_we(we0),
        .tbl_data(tdata0), .hash_out(hout0), .hash_valid(hv0),
        .busy(busy0), .byte_count(cnt0)
    );

    pearson_hash_ctrl #(.DATA_WIDTH(8), .SEED(8'hFF)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .msg_byte(msg_byte),
        .msg_valid(msg_valid), .msg_last(msg_last), .msg_ready(ready1),
        .tbl_addr(addr1), .tbl_cs(cs1), .tbl_oe(oe1), .tbl_we(we1),
        .tbl_data(tdata1), .hash_out(hout1), .hash_valid(hv1),
        .busy(busy1), .byte_count(cnt1)
    );

    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0] prev0, prev1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] cnt_exp(input int n);
`ifdef PEARSON_BYTE_CNT_EN
        return 16'(n);
`else
        return 16'(n * 0);
`endif
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_d0"}, 32'({ready0, cs0, oe0, we0, hv0, busy0, addr0, hout0, cnt0}), 0);
        check({tag, "_d1"}, 32'({ready1, cs1, oe1, we1, hv1, busy1, addr1, hout1, cnt1}), 0);
    endtask

    // Starts a message of n bytes (gap idle cycles between bytes); exp0 is the hand-computed SEED=00 hash.
    task automatic run_msg(input int n, input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input int gap, input logic [7:0] exp0);
        logic [7:0] bytes [3];
        logic [7:0] h0, h1, idx0, idx1;
        bytes[0] = b0; bytes[1] = b1; bytes[2] = b2;
        h0 = 8'h00;
        h1 = 8'hFF;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("acc_ready", 32'({ready0, ready1, busy0, busy1}), 32'hF);
        check("acc_hv", 32'({hv0, hv1}), 0);
        check("acc_cnt_clr", 32'(cnt0), 0);
        check("acc_tbl_idle", 32'({cs0, oe0, we0, addr0}), 0);
        check("hout_hold0", 32'(hout0), 32'(prev0));
        check("hout_hold1", 32'(hout1), 32'(prev1));
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin
                repeat (gap) begin
                    tick();
                    check("gap_ready", 32'({ready0, busy0, cs0}), 32'b110);
                end
            end
            msg_valid = 1'b1;
            msg_byte  = bytes[i];
            msg_last  = (i == n - 1);
            tick();
            msg_valid = 1'b0;
            msg_last  = 1'b0;
            idx0 = h0 ^ bytes[i];
            idx1 = h1 ^ bytes[i];
            check("rd_addr0", 32'(addr0), 32'(idx0));
            check("rd_addr1", 32'(addr1), 32'(idx1));
            check("rd_ctl", 32'({cs0, oe0, we0, cs1, oe1, we1}), 32'b110110);
            check("rd_ready_hv", 32'({ready0, hv0, busy0}), 32'b001);
            h0 = idx0;
            h1 = idx1;
            tick();
        end
        check("done_hv", 32'({hv0, hv1}), 32'b11);
        check("hash0", 32'(hout0), 32'(exp0));
        check("hash1", 32'(hout1), 32'(exp0 ^ 8'hFF));
        check("done_idle", 32'({ready0, busy0, cs0, oe0, we0, addr0}), 0);
        check("done_cnt", 32'(cnt0), 32'(cnt_exp(n)));
        prev0 = exp0;
        prev1 = exp0 ^ 8'hFF;
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        msg_valid = 1'b0;
        msg_last  = 1'b0;
        msg_byte  = 8'h00;
        prev0     = 8'h00;
        prev1     = 8'h00;
        repeat (2) tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();
        check_all_zero("post_reset");

        // 12^34^56 = 70, six edges start-to-DONE
        run_msg(3, 8'h12, 8'h34, 8'h56, 0, 8'h70);
        tick();
        check("done_to_idle", 32'({hv0, ready0, busy0}), 0);
        check("idle_hold", 32'(hout0), 32'h70);
        check("idle_cnt_hold", 32'(cnt0), 32'(cnt_exp(3)));

        // single byte: SEED FF instance hashes A5 to 5A
        run_msg(1, 8'hA5, 8'h00, 8'h00, 0, 8'hA5);
        tick();

        // msg_valid in IDLE without start is ignored
        msg_valid = 1'b1;
        msg_byte  = 8'h77;
        repeat (3) begin
            tick();
            check("idle_ignore", 32'({ready0, busy0, hv0, cs0}), 0);
        end
        msg_valid = 1'b0;
        check("idle_ignore_hout", 32'(hout0), 32'hA5);

        // start held in ACCEPT and pulsed in READ is ignored
        start = 1'b1;
        tick();
        tick();
        check("start_in_acc", 32'({ready0, busy0, cs0}), 32'b110);
        start     = 1'b0;
        msg_valid = 1'b1;
        msg_byte  = 8'h11;
        tick();
        msg_valid = 1'b0;
        start     = 1'b1;
        check("rd_before_start", 32'(addr0), 32'h11);
        tick();
        start = 1'b0;
        check("start_in_rd", 32'({ready0, busy0, hv0}), 32'b110);
        msg_valid = 1'b1;
        msg_byte  = 8'h22;
        msg_last  = 1'b1;
        tick();
        msg_valid = 1'b0;
        msg_last  = 1'b0;
        tick();
        check("ign_hv", 32'(hv0), 1);
        check("ign_hash0", 32'(hout0), 32'h33);
        check("ign_hash1", 32'(hout1), 32'hCC);
        check("ign_cnt", 32'(cnt0), 32'(cnt_exp(2)));
        prev0 = 8'h33;
        prev1 = 8'hCC;
        tick();

        // gapped bytes give the same hash as back-to-back
        run_msg(3, 8'h12, 8'h34, 8'h56, 3, 8'h70);

        // start in the DONE cycle: h reloads SEED, count restarts; 0F^F0 = FF
        run_msg(2, 8'h0F, 8'hF0, 8'h00, 0, 8'hFF);
        tick();

        // reset during READ of byte 2 of 3
        start = 1'b1;
        tick();
        start     = 1'b0;
        msg_valid = 1'b1;
        msg_byte  = 8'h01;
        tick();
        msg_valid = 1'b0;
        tick();
        msg_valid = 1'b1;
        msg_byte  = 8'h02;
        tick();
        msg_valid = 1'b0;
        check("pre_rst_read", 32'({cs0, addr0}), 32'h103);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        tick();
        rst_n = 1'b1;
        tick();
        check_all_zero("rst_release");
        prev0 = 8'h00;
        prev1 = 8'h00;
        run_msg(1, 8'h0F, 8'h00, 8'h00, 0, 8'h0F);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
